fetch_unit: RTL and testbench

Instruction fetch stage for the RV32 core. Holds the program counter and drives the byte address into the combinational instruction memory. Buffers each returned word with its PC in a small fetch queue and presents it to decode over a valid/ready handshake. Accepts redirects (branch, jump, trap) from execute, which flush the queue and reload the PC.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/fetch_unit_if.sv | 42 ++++
 rtl/fetch_queue.sv | 65 ++++++
 rtl/fetch_unit.sv | 64 ++++++
 tb/tb_fetch_unit.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32 core types and constants.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Instruction-memory, redirect and decode handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
  import riscv_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_instr;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr
  );

endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Small synchronous FIFO of fetch entries with flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int QUEUE_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int c_PTR_W = $clog2(QUEUE_DEPTH);
  localparam int c_CNT_W = $clog2(QUEUE_DEPTH + 1);

  fetch_entry_t       r_mem [QUEUE_DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign full  = (r_count == c_CNT_W'(QUEUE_DEPTH));
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rd_ptr];

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : RV32 instruction fetch stage: PC, fetch queue, redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  logic [XLEN-1:0] r_pc;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  fetch_entry_t    w_entry;
  fetch_entry_t    w_head;
  logic            w_unused_bits;

  // A pop frees a slot in the same edge, so a full queue can still accept.
  assign w_pop   = !w_empty && bus.out_ready;
  assign w_push  = !bus.redirect_valid && (!w_full || w_pop);
  assign w_entry = '{pc: r_pc, instr: bus.imem_instr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      r_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
    end else if (w_push) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  fetch_queue #(
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) u_fetch_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .flush (bus.redirect_valid),
    .din   (w_entry),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  assign bus.imem_addr = r_pc;
  assign bus.out_valid = !w_empty;
  assign bus.out_pc    = w_head.pc;
  assign bus.out_instr = w_head.instr;

  assign w_unused_bits = ^bus.redirect_pc[1:0];

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed table-driven bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;

  localparam int c_NVEC = 21;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  vec_t vecs [c_NVEC];

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    if (a == 32'h4) return 32'h0050_0093;
    return a ^ 32'h1357_9BDF;
  endfunction

  always_comb bus.imem_instr = mem_word(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    // rv, rpc, rdy, exp_valid, exp_pc, exp_addr
    vecs[0]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0};
    vecs[1]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h4};
    vecs[2]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h8};
    vecs[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h8};
    vecs[4]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h8};
    vecs[5]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h8};
    vecs[6]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         32'hC};
    vecs[7]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         32'h10};
    vecs[8]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hC,         32'h14};
    vecs[9]  = '{1'b1, 32'h103,       1'b0, 1'b1, 32'hC,         32'h14};
    vecs[10] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h100};
    vecs[11] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h100,       32'h104};
    vecs[12] = '{1'b1, 32'hFFFF_FFFA, 1'b1, 1'b1, 32'h104,       32'h108};
    vecs[13] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'hFFFF_FFF8};
    vecs[14] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
    vecs[15] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0};
    vecs[16] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h4};
    vecs[17] = '{1'b1, 32'h200,       1'b1, 1'b1, 32'h4,         32'h8};
    vecs[18] = '{1'b1, 32'h300,       1'b1, 1'b0, 32'h0,         32'h200};
    vecs[19] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h300};
    vecs[20] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h300,       32'h304};

    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("reset_addr",  bus.imem_addr, 32'h0);
    chk("reset_pc",    bus.out_pc,    32'h0);
    chk("reset_instr", bus.out_instr, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < c_NVEC; i++) begin
      bus.redirect_valid = vecs[i].rv;
      bus.redirect_pc    = vecs[i].rpc;
      bus.out_ready      = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_valid", i), {31'h0, bus.out_valid}, {31'h0, vecs[i].ev});
      chk($sformatf("v%0d_addr", i), bus.imem_addr, vecs[i].eaddr);
      if (vecs[i].ev) begin
        chk($sformatf("v%0d_pc", i), bus.out_pc, vecs[i].epc);
        chk($sformatf("v%0d_instr", i), bus.out_instr, mem_word(vecs[i].epc));
      end
      @(negedge clk);
    end

    // Fill the queue, then assert reset between edges.
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("prereset_valid", {31'h0, bus.out_valid}, 32'h1);
    chk("prereset_pc",    bus.out_pc,    32'h304);
    chk("prereset_addr",  bus.imem_addr, 32'h30C);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("async_rst_addr",  bus.imem_addr, 32'h0);
    chk("async_rst_pc",    bus.out_pc,    32'h0);
    chk("async_rst_instr", bus.out_instr, 32'h0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("release_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("release_addr",  bus.imem_addr, 32'h0);
    @(negedge clk);
    #1;
    chk("first_valid", {31'h0, bus.out_valid}, 32'h1);
    chk("first_pc",    bus.out_pc,    32'h0);
    chk("first_instr", bus.out_instr, 32'h0000_0013);
    chk("first_addr",  bus.imem_addr, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
